// File: rtl/memshare_c2v_wb_serializer.sv
// Write-back serializer: latches one shared-bank result request and emits one C2V MEM
// write per accepted cycle in ascending bank order. Optional parity bit: MEMSHARE_WB_PARITY_EN.
module memshare_c2v_wb_serializer #(
    parameter int SHARED_BANK_NUM       = 4,
    parameter int QUAN_SIZE             = 4,
    parameter int C2V_MEM_ADDR_BITWIDTH = 10,
    parameter int CNT_BITWIDTH          = 8
) (
    input  logic                                 sys_clk,
    input  logic                                 rstn,
    input  logic                                 rqst_valid_i,
    output logic                                 rqst_ready_o,
    input  logic [SHARED_BANK_NUM-1:0]           rqst_mask_i,
    input  logic [C2V_MEM_ADDR_BITWIDTH-1:0]     rqst_addr_i,
    input  logic [SHARED_BANK_NUM*QUAN_SIZE-1:0] rqst_data_i,
    output logic                                 mem_we_o,
    input  logic                                 mem_ready_i,
    output logic [C2V_MEM_ADDR_BITWIDTH-1:0]     mem_waddr_o,
`ifdef MEMSHARE_WB_PARITY_EN
    output logic [QUAN_SIZE:0]                   mem_wdata_o,
`else
    output logic [QUAN_SIZE-1:0]                 mem_wdata_o,
`endif
    output logic                                 wb_done_o,
    output logic [CNT_BITWIDTH-1:0]              wr_count_o
);

    localparam int IDX_W = (SHARED_BANK_NUM > 1) ? $clog2(SHARED_BANK_NUM) : 1;
`ifdef MEMSHARE_WB_PARITY_EN
    localparam int WD_W = QUAN_SIZE + 1;
`else
    localparam int WD_W = QUAN_SIZE;
`endif

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                                 state_q, state_d;
    logic [SHARED_BANK_NUM-1:0]             mask_q, mask_d;
    logic [C2V_MEM_ADDR_BITWIDTH-1:0]       addr_q, addr_d;
    logic [SHARED_BANK_NUM*QUAN_SIZE-1:0]   data_q, data_d;
    logic                                   we_q, we_d;
    logic [C2V_MEM_ADDR_BITWIDTH-1:0]       waddr_q, waddr_d;
    logic [WD_W-1:0]                        wdata_q, wdata_d;
    logic                                   done_q, done_d;
    logic                                   ready_q, ready_d;
    logic [CNT_BITWIDTH-1:0]                cnt_q, cnt_d;

    logic [SHARED_BANK_NUM-1:0]             mask_rem;
    logic [IDX_W-1:0]                       k_in;
    logic [IDX_W-1:0]                       k_next;

    function automatic logic [IDX_W-1:0] lowest_bank(input logic [SHARED_BANK_NUM-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = SHARED_BANK_NUM - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [WD_W-1:0] bank_word(
        input logic [SHARED_BANK_NUM*QUAN_SIZE-1:0] d,
        input logic [IDX_W-1:0]                     k
    );
        logic [QUAN_SIZE-1:0] msg;
        msg = d[int'(k)*QUAN_SIZE +: QUAN_SIZE];
`ifdef MEMSHARE_WB_PARITY_EN
        return {^msg, msg};
`else
        return msg;
`endif
    endfunction

    function automatic logic [C2V_MEM_ADDR_BITWIDTH-1:0] bank_addr(
        input logic [C2V_MEM_ADDR_BITWIDTH-1:0] base,
        input logic [IDX_W-1:0]                 k
    );
        return base + C2V_MEM_ADDR_BITWIDTH'(k);
    endfunction

    // Clearing the lowest set bit retires the bank currently on the bus.
    assign mask_rem = mask_q & (mask_q - SHARED_BANK_NUM'(1));
    assign k_next   = lowest_bank(mask_rem);
    assign k_in     = lowest_bank(rqst_mask_i);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (rqst_valid_i && ready_q) begin
                    mask_d  = rqst_mask_i;
                    addr_d  = rqst_addr_i;
                    data_d  = rqst_data_i;
                    ready_d = 1'b0;
                    if (rqst_mask_i != '0) begin
                        state_d = DRAIN;
                        we_d    = 1'b1;
                        waddr_d = bank_addr(rqst_addr_i, k_in);
                        wdata_d = bank_word(rqst_data_i, k_in);
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (we_q && mem_ready_i) begin
                    mask_d = mask_rem;
                    cnt_d  = cnt_q + CNT_BITWIDTH'(1);
                    if (mask_rem != '0) begin
                        waddr_d = bank_addr(addr_q, k_next);
                        wdata_d = bank_word(data_q, k_next);
                    end else begin
                        we_d    = 1'b0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rqst_ready_o = ready_q;
    assign mem_we_o     = we_q;
    assign mem_waddr_o  = waddr_q;
    assign mem_wdata_o  = wdata_q;
    assign wb_done_o    = done_q;
    assign wr_count_o   = cnt_q;

endmodule

// File: tb/tb_memshare_c2v_wb_serializer.sv
// Bench for memshare_c2v_wb_serializer: directed cases plus randomized requests scored
// against an expected-write queue built from the mask/address/data of each request.
module tb_memshare_c2v_wb_serializer;

    localparam int NB = 4;
    localparam int QS = 4;
    localparam int AW = 10;
    localparam int CW = 8;
`ifdef MEMSHARE_WB_PARITY_EN
    localparam int WDW = QS + 1;
`else
    localparam int WDW = QS;
`endif

    logic             sys_clk = 1'b0;
    logic             rstn = 1'b0;
    logic             rqst_valid_i = 1'b0;
    logic             rqst_ready_o;
    logic [NB-1:0]    rqst_mask_i = '0;
    logic [AW-1:0]    rqst_addr_i = '0;
    logic [NB*QS-1:0] rqst_data_i = '0;
    logic             mem_we_o;
    logic             mem_ready_i = 1'b0;
    logic [AW-1:0]    mem_waddr_o;
    logic [WDW-1:0]   mem_wdata_o;
    logic             wb_done_o;
    logic [CW-1:0]    wr_count_o;

    memshare_c2v_wb_serializer #(
        .SHARED_BANK_NUM(NB), .QUAN_SIZE(QS),
        .C2V_MEM_ADDR_BITWIDTH(AW), .CNT_BITWIDTH(CW)
    ) dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .rqst_valid_i(rqst_valid_i), .rqst_ready_o(rqst_ready_o),
        .rqst_mask_i(rqst_mask_i), .rqst_addr_i(rqst_addr_i), .rqst_data_i(rqst_data_i),
        .mem_we_o(mem_we_o), .mem_ready_i(mem_ready_i),
        .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .wb_done_o(wb_done_o), .wr_count_o(wr_count_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AW-1:0]  a;
        logic [WDW-1:0] d;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  exp_cnt = 0;
    wr_t expq[$];

    function automatic logic [WDW-1:0] model_word(input logic [QS-1:0] msg);
        logic [QS:0] w;
        w = {1'b0, msg};
        if ($countones(msg) % 2 == 1) w[QS] = 1'b1;
        return WDW'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // rmode: 0 = memory always ready, 1 = random ready, 2 = stall on the second write cycle only
    task automatic do_req(input logic [NB-1:0] m, input logic [AW-1:0] a,
                          input logic [NB*QS-1:0] d, input int rmode);
        int  cyc;
        wr_t w;
        logic [QS-1:0] msg;
        logic rdy;
        chk("ready_idle", 32'(rqst_ready_o), 32'd1);
        expq.delete();
        for (int b = 0; b < NB; b++) begin
            if (m[b]) begin
                msg = d[b*QS +: QS];
                w.a = AW'((int'(a) + b) % (1 << AW));
                w.d = model_word(msg);
                expq.push_back(w);
            end
        end
        rqst_valid_i = 1'b1;
        rqst_mask_i  = m;
        rqst_addr_i  = a;
        rqst_data_i  = d;
        mem_ready_i  = 1'b1;
        tick();
        cyc = 0;
        while (expq.size() > 0 && cyc < 200) begin
            rqst_valid_i = 1'($urandom);
            rqst_mask_i  = NB'($urandom);
            rqst_addr_i  = AW'($urandom);
            rqst_data_i  = (NB*QS)'($urandom);
            chk("ready_busy", 32'(rqst_ready_o), 32'd0);
            chk("we", 32'(mem_we_o), 32'd1);
            chk("waddr", 32'(mem_waddr_o), 32'(expq[0].a));
            chk("wdata", 32'(mem_wdata_o), 32'(expq[0].d));
            chk("done_early", 32'(wb_done_o), 32'd0);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom % 4) != 0;
                default: rdy = (cyc != 1);
            endcase
            mem_ready_i = rdy;
            if (rdy) begin
                void'(expq.pop_front());
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            tick();
            cyc++;
        end
        if (expq.size() > 0) chk("drain_timeout", 32'(expq.size()), 32'd0);
        rqst_valid_i = 1'b0;
        mem_ready_i  = 1'($urandom);
        chk("done_pulse", 32'(wb_done_o), 32'd1);
        chk("we_after", 32'(mem_we_o), 32'd0);
        chk("ready_in_done", 32'(rqst_ready_o), 32'd0);
        chk("count", 32'(wr_count_o), 32'(exp_cnt));
        tick();
        chk("done_one_cycle", 32'(wb_done_o), 32'd0);
        chk("ready_back", 32'(rqst_ready_o), 32'd1);
        chk("we_idle", 32'(mem_we_o), 32'd0);
    endtask

    initial begin
        // Reset held with valid asserted
        rqst_valid_i = 1'b1;
        rqst_mask_i  = '1;
        rqst_addr_i  = 10'h155;
        rqst_data_i  = 16'hFFFF;
        mem_ready_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_we", 32'(mem_we_o), 32'd0);
            chk("rst_waddr", 32'(mem_waddr_o), 32'd0);
            chk("rst_wdata", 32'(mem_wdata_o), 32'd0);
            chk("rst_done", 32'(wb_done_o), 32'd0);
            chk("rst_count", 32'(wr_count_o), 32'd0);
            chk("rst_ready", 32'(rqst_ready_o), 32'd0);
        end
        rstn = 1'b1;
        rqst_valid_i = 1'b0;
        tick();
        chk("post_rst_ready", 32'(rqst_ready_o), 32'd1);
        chk("post_rst_we", 32'(mem_we_o), 32'd0);

        // Directed: basic three-bank request, stalled variant, address wrap, empty mask
        do_req(4'b1011, 10'h010, 16'h9375, 0);
        do_req(4'b1011, 10'h010, 16'h9375, 2);
        do_req(4'b1000, 10'h3FE, 16'hA123, 0);
        do_req(4'b0000, 10'h200, 16'hBEEF, 0);
        do_req(4'b0000, 10'h201, 16'h1234, 0);
        do_req(4'b1111, 10'h3FD, 16'hFEDC, 1);

        // Randomized requests with random memory back-pressure
        for (int n = 0; n < 40; n++) begin
            do_req(NB'($urandom), AW'($urandom), (NB*QS)'($urandom), 1);
        end

        // Reset in the middle of a drain drops the remaining writes
        chk("mid_ready", 32'(rqst_ready_o), 32'd1);
        rqst_valid_i = 1'b1;
        rqst_mask_i  = 4'b1011;
        rqst_addr_i  = 10'h010;
        rqst_data_i  = 16'h9375;
        mem_ready_i  = 1'b1;
        tick();
        rqst_valid_i = 1'b0;
        chk("mid_we1", 32'(mem_we_o), 32'd1);
        chk("mid_waddr1", 32'(mem_waddr_o), 32'h010);
        chk("mid_wdata1", 32'(mem_wdata_o), 32'(model_word(4'h5)));
        tick();
        chk("mid_waddr2", 32'(mem_waddr_o), 32'h011);
        chk("mid_wdata2", 32'(mem_wdata_o), 32'(model_word(4'h7)));
        rstn = 1'b0;
        tick();
        exp_cnt = 0;
        chk("mid_rst_we", 32'(mem_we_o), 32'd0);
        chk("mid_rst_waddr", 32'(mem_waddr_o), 32'd0);
        chk("mid_rst_wdata", 32'(mem_wdata_o), 32'd0);
        chk("mid_rst_count", 32'(wr_count_o), 32'd0);
        chk("mid_rst_ready", 32'(rqst_ready_o), 32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_after_we", 32'(mem_we_o), 32'd0);
            chk("mid_after_count", 32'(wr_count_o), 32'd0);
        end
        do_req(4'b0110, 10'h0F0, 16'h4C2D, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
